// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounces N synchronized inputs and round-robins their press/release
// events onto one valid/ready port.
module button_event_arbiter #(
    parameter int channels = 4,
    parameter int debounce_cycles = 16,
    localparam int cnt_w = $clog2(debounce_cycles),
    localparam int cw = $clog2(channels)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [channels-1:0] sync_input,
    input  logic                event_ready,
    output logic                event_valid,
    output logic [cw-1:0]       event_channel,
    output logic                event_press,
    output logic [channels-1:0] debounced_state,
    output logic                overflow
);
    typedef enum logic {IDLE, OFFER} state_t;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(debounce_cycles - 1);
    state_t              state;
    logic [cnt_w-1:0]    cnt [channels];
    logic [channels-1:0] strobe, pending, pending_level, grant;
    logic [cw-1:0]       rr, sel, idx;
    logic                found;
    always_comb begin
        strobe = '0;
        for (int k = 0; k < channels; k++)
            strobe[k] = (sync_input[k] != debounced_state[k]) && (cnt[k] == cnt_max);
    end
    // first pending channel at or after rr, wrapping
    always_comb begin
        sel = '0;
        idx = '0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < channels; k++) begin
            idx = cw'((int'(rr) + k) % channels);
            if (!found && pending[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
        if (state == IDLE && found) grant[sel] = 1'b1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < channels; k++) cnt[k] <= '0;
            debounced_state <= '0;
            pending <= '0;
            pending_level <= '0;
            overflow <= 1'b0;
        end else begin
            for (int k = 0; k < channels; k++)
                cnt[k] <= (sync_input[k] == debounced_state[k] || strobe[k]) ? '0 : cnt[k] + 1'b1;
            debounced_state <= debounced_state ^ strobe;
            pending <= (pending & ~grant) | strobe;
            pending_level <= (pending_level & ~strobe) | (sync_input & strobe);
            // a channel being granted this edge has already vacated its pending slot
            overflow <= |(strobe & pending & ~grant);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rr <= '0;
            event_valid <= 1'b0;
            event_channel <= '0;
            event_press <= 1'b0;
        end else if (state == IDLE) begin
            if (found) begin
                event_channel <= sel;
                event_press <= pending_level[sel];
                event_valid <= 1'b1;
                state <= OFFER;
            end
        end else if (event_ready) begin
            event_valid <= 1'b0;
            rr <= (event_channel == cw'(channels - 1)) ? '0 : event_channel + 1'b1;
            state <= IDLE;
        end
    end
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Debounces N already-synchronized button/switch inputs and turns each debounced edge into a press/release event.
- Round-robin arbitrates pending events from all channels onto a single valid/ready event port.
- Sits between the per-pin two-flop synchronizer stage and the FSM/UI logic that consumes button events.
- Lets one consumer serve every input channel without missing edges.

Parameters:
- channels, 4, number of input channels (>=2).
- debounce_cycles, 16, consecutive mismatching cycles required to accept a new level (>=2).
- Derived: counter width = $clog2(debounce_cycles); channel index width cw = $clog2(channels).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- sync_input  input  channels  already-synchronized raw levels, one bit per channel.
- event_ready  input  1  consumer accepts the current event this cycle.
- event_valid  output  1  event_channel/event_press hold a valid event.
- event_channel  output  cw  index of the channel that produced the event.
- event_press  output  1  1 = debounced rising edge (press), 0 = falling edge (release).
- debounced_state  output  channels  current debounced level of every channel.
- overflow  output  1  one-cycle pulse: an event was overwritten before it was delivered.

Behaviour:
- Reset (reset_n=0, async): all debounce counters=0, debounced_state=0, pending=0, pending_level=0, rr pointer=0, FSM=IDLE, event_valid=0, event_channel=0, event_press=0, overflow=0.
- Reset mid-offer discards the offered event and all pending events.
- Debounce, per channel i, each edge:
  - sync_input[i]==debounced_state[i]: counter cleared to 0.
  - mismatch and counter<debounce_cycles-1: counter+1.
  - mismatch and counter==debounce_cycles-1: debounced_state[i] toggles, counter=0, edge_strobe[i] fires.
  - Result: a level stable from the first mismatching sample (edge 1) toggles at edge debounce_cycles.
  - Any shorter glitch produces no toggle and no event.
- Pending capture, on edge_strobe[i]:
  - pending[i]=1 and pending_level[i]=new level.
  - If pending[i] was already 1 on that same edge: old event is replaced and overflow pulses high for exactly one cycle.
  - Multiple channels may strobe on the same edge; all are captured.
  - overflow is the OR over channels.
- Arbiter FSM, two states:
  - IDLE: if any pending bit is set, select the first set index searching from rr pointer upward, wrapping modulo channels.
  - On that edge: load event_channel=idx and event_press=pending_level[idx], clear pending[idx], set event_valid=1, go to OFFER.
  - If no pending bit is set: stay in IDLE, event_valid=0.
  - OFFER: event_valid, event_channel and event_press are held stable until event_valid&&event_ready.
  - On handshake: event_valid=0, rr pointer = (event_channel+1) mod channels, go to IDLE.
  - event_ready while in IDLE is ignored.
- Simultaneous events:
  - A strobe on a channel in the same cycle it is latched into OFFER sets pending again (new event). This is not an overflow, because the prior event left pending that cycle.
  - A strobe on the offered channel during OFFER creates a new pending event; the offered value is unaffected.
- Latency: stable input first mismatching sample at edge 1 -> debounced_state toggles at edge D -> event_valid high after edge D+1. Maximum throughput is one event per 2 cycles.
- Fairness: after channel k is served, channel k is lowest priority, so no channel waits more than channels-1 grants.

Test Plan:
- Reset then idle, D=4: sync_input=0 held, event_ready=1 -> event_valid, debounced_state and overflow all 0 for 50 cycles. Assert reset_n mid-OFFER -> all outputs 0 immediately (asynchronous, before next clk edge).
- Single press, D=4: sync_input[2] 0->1 before edge 1, event_ready=1 -> debounced_state[2]=1 after edge 4; event_valid=1, channel=2, press=1 after edge 5; valid=0 after edge 6. Release repeats with press=0.
- Glitch reject, D=4: sync_input[0] high for 3 cycles then low -> no toggle, no event, counter back to 0.
- Round-robin: channels 0,1,3 strobe on the same edge, event_ready=1 -> events delivered in order 0,1,3. Then ch0 and ch1 pend with pointer=0 after ch3 -> order 0 then 1.
- Backpressure: event_ready=0 for 20 cycles during OFFER on ch1 -> outputs stay stable. Meanwhile ch1 releases (second edge) -> new pending, no overflow. ch1 presses again while still pending -> overflow pulses 1 cycle; after ready, delivered events are the original ch1 press then ch1 press (latest level).
- Wrap-around: channels=4, pointer=3, pending on ch0 and ch2 -> ch0 delivered first, then ch2.
